// File: rtl/pong_frame_engine_if.sv
// pong_frame_engine_if: frame engine control inputs and game-state outputs
interface pong_frame_engine_if #(parameter int XW = 10, YW = 9, SW = 4);
  logic frame_tick, p1_up, p1_down, p2_up, p2_down, start;
  logic [XW-1:0] ball_x;
  logic [YW-1:0] ball_y, p1_y, p2_y;
  logic [SW-1:0] score1, score2;
  logic [1:0] state, winner;
  logic goal;
  modport master(
    output frame_tick, p1_up, p1_down, p2_up, p2_down, start,
    input ball_x, ball_y, p1_y, p2_y, score1, score2, state, goal, winner
  );
  modport slave(
    input frame_tick, p1_up, p1_down, p2_up, p2_down, start,
    output ball_x, ball_y, p1_y, p2_y, score1, score2, state, goal, winner
  );
endinterface

// File: rtl/pong_frame_engine.sv
// pong_frame_engine: per-frame ball, paddle, score and match-state update for two-player pong
module pong_frame_engine #(
  parameter int WIDTH = 640, HEIGHT = 480, XW = 10, YW = 9,
  parameter int P1_X = 80, P2_X = 560, PAD_HW = 5, PAD_HH = 33,
  parameter int BALL_HW = 10, BALL_HH = 15, BALL_STEP = 2, PAD_STEP = 3,
  parameter int SERVE_FRAMES = 60, GOAL_FRAMES = 30, WIN_SCORE = 7, SW = 4
) (
  input logic clk,
  input logic reset,
  pong_frame_engine_if.slave bus
);
  localparam int NW = (XW > YW ? XW : YW) + 2;
  localparam int CW = $clog2((SERVE_FRAMES > GOAL_FRAMES ? SERVE_FRAMES : GOAL_FRAMES) + 1);
  typedef logic signed [NW-1:0] sn_t;
  typedef enum logic [1:0] {SERVE, PLAY, GOAL, OVER} state_t;
  // Edge tests are pre-folded so that x/y are compared directly against a limit
  localparam sn_t S_Z = '0;
  localparam sn_t S_BS = sn_t'(BALL_STEP);
  localparam sn_t S_PS = sn_t'(PAD_STEP);
  localparam sn_t S_PH = sn_t'(PAD_HH);
  localparam sn_t S_PMAX = sn_t'(HEIGHT - 1 - PAD_HH);
  localparam sn_t S_BHW = sn_t'(BALL_HW);
  localparam sn_t S_BHH = sn_t'(BALL_HH);
  localparam sn_t S_XMAX = sn_t'(WIDTH - 1 - BALL_HW);
  localparam sn_t S_YMAX = sn_t'(HEIGHT - 1 - BALL_HH);
  localparam sn_t S_P1L = sn_t'(P1_X + PAD_HW + BALL_HW);
  localparam sn_t S_P2L = sn_t'(P2_X - PAD_HW - BALL_HW);
  localparam sn_t S_HIT = sn_t'(PAD_HH + BALL_HH);
  localparam logic [XW-1:0] CX = XW'(WIDTH / 2);
  localparam logic [YW-1:0] CY = YW'(HEIGHT / 2);
  localparam logic [SW-1:0] WS = SW'(WIN_SCORE);
  state_t r_state, n_state;
  logic [XW-1:0] r_bx, n_bx;
  logic [YW-1:0] r_by, n_by, r_p1, n_p1, r_p2, n_p2;
  logic [SW-1:0] r_s1, n_s1, r_s2, n_s2;
  logic [CW-1:0] r_cnt, n_cnt;
  logic [1:0] r_win, n_win;
  logic r_dx, n_dx, r_dy, n_dy, r_goal, n_goal;
  sn_t w_x, w_y, w_nx, w_ny, w_d1, w_d2;
  logic w_hit1, w_hit2, w_last_serve, w_last_goal, w_over;
  function automatic logic [YW-1:0] pad_nxt(input logic [YW-1:0] y, input logic up, input logic dn);
    sn_t v;
    v = sn_t'(y) + (up && !dn ? -S_PS : dn && !up ? S_PS : S_Z);
    return v < S_PH ? YW'(S_PH) : v > S_PMAX ? YW'(S_PMAX) : YW'(v);
  endfunction
  assign w_x = sn_t'(r_bx);
  assign w_y = sn_t'(r_by);
  assign w_nx = r_dx ? w_x + S_BS : w_x - S_BS;
  assign w_ny = r_dy ? w_y + S_BS : w_y - S_BS;
  assign w_d1 = w_y - sn_t'(r_p1);
  assign w_d2 = w_y - sn_t'(r_p2);
  assign w_hit1 = !r_dx && w_x > S_P1L && w_nx <= S_P1L && w_d1 <= S_HIT && w_d1 >= -S_HIT;
  assign w_hit2 = r_dx && w_x < S_P2L && w_nx >= S_P2L && w_d2 <= S_HIT && w_d2 >= -S_HIT;
  assign w_last_serve = r_cnt == CW'(SERVE_FRAMES - 1);
  assign w_last_goal = r_cnt == CW'(GOAL_FRAMES - 1);
  assign w_over = r_s1 == WS || r_s2 == WS;
  always_comb begin
    n_state = r_state;
    n_bx = r_bx;
    n_by = r_by;
    n_p1 = r_p1;
    n_p2 = r_p2;
    n_s1 = r_s1;
    n_s2 = r_s2;
    n_cnt = r_cnt;
    n_win = r_win;
    n_dx = r_dx;
    n_dy = r_dy;
    n_goal = 1'b0;
    if (r_state == OVER) begin
      if (bus.start) begin
        n_s1 = '0;
        n_s2 = '0;
        n_win = 2'd0;
        n_dx = 1'b1;
        n_dy = 1'b1;
        n_bx = CX;
        n_by = CY;
        n_state = SERVE;
      end
    end else if (bus.frame_tick) begin
      n_p1 = pad_nxt(r_p1, bus.p1_up, bus.p1_down);
      n_p2 = pad_nxt(r_p2, bus.p2_up, bus.p2_down);
      if (r_state == SERVE) begin
        n_cnt = w_last_serve ? '0 : r_cnt + 1'b1;
        n_state = w_last_serve ? PLAY : SERVE;
      end else if (r_state == GOAL) begin
        n_cnt = w_last_goal ? '0 : r_cnt + 1'b1;
        if (w_last_goal) begin
          n_bx = CX;
          n_by = CY;
          n_state = w_over ? OVER : SERVE;
          n_win = !w_over ? 2'd0 : r_s1 == WS ? 2'd1 : 2'd2;
        end
      end else begin
        n_by = w_ny <= S_BHH ? YW'(S_BHH) : w_ny >= S_YMAX ? YW'(S_YMAX) : YW'(w_ny);
        n_dy = w_ny <= S_BHH ? 1'b1 : w_ny >= S_YMAX ? 1'b0 : r_dy;
        // A goal tick leaves x where it was; the ball freezes there through GOAL
        if (w_hit1) begin
          n_bx = XW'(S_P1L + 1);
          n_dx = 1'b1;
        end else if (w_hit2) begin
          n_bx = XW'(S_P2L - 1);
          n_dx = 1'b0;
        end else if (w_nx <= S_BHW) begin
          n_s2 = r_s2 == WS ? r_s2 : r_s2 + 1'b1;
          n_dx = 1'b1;
          n_goal = 1'b1;
          n_state = GOAL;
        end else if (w_nx >= S_XMAX) begin
          n_s1 = r_s1 == WS ? r_s1 : r_s1 + 1'b1;
          n_dx = 1'b0;
          n_goal = 1'b1;
          n_state = GOAL;
        end else begin
          n_bx = XW'(w_nx);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= SERVE;
      r_bx <= CX;
      r_by <= CY;
      r_p1 <= CY;
      r_p2 <= CY;
      r_s1 <= '0;
      r_s2 <= '0;
      r_cnt <= '0;
      r_win <= 2'd0;
      r_dx <= 1'b1;
      r_dy <= 1'b1;
      r_goal <= 1'b0;
    end else begin
      r_state <= n_state;
      r_bx <= n_bx;
      r_by <= n_by;
      r_p1 <= n_p1;
      r_p2 <= n_p2;
      r_s1 <= n_s1;
      r_s2 <= n_s2;
      r_cnt <= n_cnt;
      r_win <= n_win;
      r_dx <= n_dx;
      r_dy <= n_dy;
      r_goal <= n_goal;
    end
  assign bus.ball_x = r_bx;
  assign bus.ball_y = r_by;
  assign bus.p1_y = r_p1;
  assign bus.p2_y = r_p2;
  assign bus.score1 = r_s1;
  assign bus.score2 = r_s2;
  assign bus.state = r_state;
  assign bus.goal = r_goal;
  assign bus.winner = r_win;
endmodule

// File: doc/pong_frame_engine.md
# pong_frame_engine

Frame-rate game-state engine for the two-player pong display. It holds ball position and direction, both paddle positions, the scores and the match state, and advances all of them once per frame tick (the VGA timing generator's `screenEnd`). It replaces the inline per-frame `always` logic in the VGA top level with a parametrised, fully synchronous block. The pixel compare and colour path read its position outputs.

## Interface
Parameters:
- `WIDTH`, 640: active screen width in pixels
- `HEIGHT`, 480: active screen height in pixels
- `XW`, 10: x coordinate width; must satisfy 2^XW > WIDTH
- `YW`, 9: y coordinate width; must satisfy 2^YW > HEIGHT
- `P1_X`, 80: fixed x centre of paddle 1
- `P2_X`, 560: fixed x centre of paddle 2
- `PAD_HW`, 5: paddle half-width
- `PAD_HH`, 33: paddle half-height
- `BALL_HW`, 10: ball half-width
- `BALL_HH`, 15: ball half-height
- `BALL_STEP`, 2: ball pixels per tick, per axis
- `PAD_STEP`, 3: paddle pixels per tick
- `SERVE_FRAMES`, 60: ticks spent in SERVE
- `GOAL_FRAMES`, 30: ticks spent in GOAL
- `WIN_SCORE`, 7: score that ends the match
- `SW`, 4: score width

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse, synchronous to `clk`, once per frame
- `p1_up`, `p1_down`, `p2_up`, `p2_down` in 1 each: level-sensitive, sampled on `frame_tick`
- `start` in 1: level; restarts the match from GAMEOVER
- `ball_x` out XW: ball centre x
- `ball_y` out YW: ball centre y
- `p1_y`, `p2_y` out YW: paddle centre y
- `score1`, `score2` out SW: match scores
- `state` out 2: 0 = SERVE, 1 = PLAY, 2 = GOAL, 3 = GAMEOVER
- `goal` out 1: one-cycle pulse when a point is scored
- `winner` out 2: 0 = none, 1 = player 1, 2 = player 2

## Operation
- Register updates happen only in a `clk` cycle where `frame_tick` = 1, except the `start` check in GAMEOVER and the clearing of `goal`.
- Reset values:
  - ball at (WIDTH/2, HEIGHT/2); `p1_y` = `p2_y` = HEIGHT/2
  - scores 0, `state` = SERVE, frame counter 0, `goal` 0, `winner` 0
  - direction dx = +1 (right), dy = +1 (down)
- Paddles move on every tick in every state except GAMEOVER:
  - up only: y − PAD_STEP; down only: y + PAD_STEP
  - both or neither: hold
  - clamp to [PAD_HH, HEIGHT−1−PAD_HH]
- SERVE:
  - ball is held at the centre and the counter increments each tick
  - on the tick where counter = SERVE_FRAMES−1: counter ← 0, state ← PLAY
- PLAY: each tick, compute nx = x ± BALL_STEP and ny = y ± BALL_STEP, then resolve in the following priority:
  1. Vertical walls:
     - ny − BALL_HH ≤ 0: y ← BALL_HH, dy ← +1
     - ny + BALL_HH ≥ HEIGHT−1: y ← HEIGHT−1−BALL_HH, dy ← −1
     - otherwise y ← ny
  2. Paddle 1, only when dx = −1:
     - hit when x − BALL_HW > P1_X+PAD_HW, nx − BALL_HW ≤ P1_X+PAD_HW, and |y − p1_y| ≤ PAD_HH+BALL_HH (pre-update y values)
     - on hit: x ← P1_X+PAD_HW+BALL_HW+1, dx ← +1
  3. Paddle 2 mirrors paddle 1 with dx = +1, edge P2_X−PAD_HW; on hit x ← P2_X−PAD_HW−BALL_HW−1, dx ← −1.
  4. Goals, only if no paddle hit:
     - nx − BALL_HW ≤ 0: score2 += 1, serve direction dx ← +1
     - nx + BALL_HW ≥ WIDTH−1: score1 += 1, serve direction dx ← −1
     - on either goal: `goal` pulses, state ← GOAL
  5. Otherwise x ← nx.
- GOAL:
  - ball frozen at its last position
  - after GOAL_FRAMES ticks: ball re-centred, dy kept, counter 0
  - then state ← GAMEOVER with `winner` set if either score equals WIN_SCORE, else state ← SERVE
- GAMEOVER:
  - all positions and scores held
  - `start` = 1 on any cycle: scores 0, `winner` 0, dx = +1, dy = +1, ball centred, state ← SERVE
- Arithmetic: comparisons use signed intermediates of width max(XW, YW)+2, so near-edge subtraction never wraps. Scores saturate at WIN_SCORE.

## Timing
- All outputs registered. An update triggered by `frame_tick` in cycle N is visible in cycle N+1; latency is 1 cycle.
- `goal` is high exactly in cycle N+1 of the scoring tick and low otherwise.
- Back-to-back `frame_tick` pulses on consecutive cycles are each processed.
- Reset asserted mid-frame: all outputs take reset values immediately (asynchronous). Release is synchronous to the next `clk` edge.
- `start` and `frame_tick` in the same GAMEOVER cycle: `start` wins and no movement occurs that cycle.

## Test plan
- Reset then 60 ticks, no inputs -> state SERVE through tick 59, state = 1 after tick 60, ball (320,240); the next tick gives ball (322,242).
- In PLAY, hold `p1_up` for 100 ticks -> `p1_y` falls by 3 per tick and clamps at 33; `p2_up` and `p2_down` held together -> `p2_y` stays 240.
- Ball at (97,240), dx −1, `p1_y` 240 -> after one tick x = 96 and dx = +1; with `p1_y` = 400 instead -> no hit, ball continues left and a later tick scores for player 2: `goal` 1 for one cycle, score2 = 1, state GOAL.
- Ball y = 16, dy −1 -> next tick y = 15, dy = +1; corner case of ball at y = 16 and x = 11 with dx −1 -> wall and goal resolve in the same tick.
- Force score1 = 6, then a player-1 goal -> after 30 GOAL ticks state = 3, `winner` = 1; ticks in GAMEOVER change nothing; `start` pulse -> scores 0, state SERVE next cycle.
- Drop `reset` mid-PLAY, between clock edges -> outputs return to reset values before the next `clk` edge.
